// File: rtl/vga_mon_pkg.sv
// Shared definitions for the VGA frame monitor: TinyVGA pin map,
// CRC-16-CCITT constants and the lock state machine encoding.
package vga_mon_pkg;

  // TinyVGA PMOD bit positions inside the 8-bit vga_in bus
  localparam int PIN_R1    = 0;
  localparam int PIN_G1    = 1;
  localparam int PIN_B1    = 2;
  localparam int PIN_VSYNC = 3;
  localparam int PIN_R0    = 4;
  localparam int PIN_G0    = 5;
  localparam int PIN_B0    = 6;
  localparam int PIN_HSYNC = 7;

  // Every colour pin; any of these set outside the visible area is a blanking fault
  localparam logic [7:0] COLOUR_MASK = 8'b0111_0111;

  // CRC-16-CCITT, non-reflected, no final XOR
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // SEEK: waiting for a vsync edge to align on; LOCK: timing is being checked
  typedef enum logic [0:0] {
    ST_SEEK = 1'b0,
    ST_LOCK = 1'b1
  } mon_state_e;

  // Gather the six colour pins into the CRC bit order {R1,R0,G1,G0,B1,B0}
  function automatic logic [5:0] pixel_bits(input logic [7:0] v);
    return {v[PIN_R1], v[PIN_R0], v[PIN_G1], v[PIN_G0], v[PIN_B1], v[PIN_B0]};
  endfunction

endpackage

// File: rtl/vga_crc16_step.sv
// One pixel's worth of CRC-16-CCITT: folds six bits into the running CRC,
// most significant pixel bit first. Purely combinational.
module vga_crc16_step
  import vga_mon_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [5:0]  pixel,
  output logic [15:0] crc_out
);

  logic [15:0] work;

  // Bit-serial LFSR unrolled over the six pixel bits
  always_comb begin
    work = crc_in;
    for (int i = 5; i >= 0; i--) begin
      if (work[15] ^ pixel[i]) begin
        work = {work[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        work = {work[14:0], 1'b0};
      end
    end
    crc_out = work;
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// Passive VGA timing checker and frame signature generator.
// Registers the TinyVGA bus, rebuilds the raster position from the sync
// edges, checks line/frame periods, hsync width and blanking, and reports a
// CRC plus pixel count for each frame that was observed cleanly under lock.
// frame_valid is a one-cycle strobe with no back-pressure: frame_crc,
// pixel_count and frame_count are updated on the same edge that raises it
// and hold until the next strobe.
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       vga_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             frame_valid,
  output logic [15:0]      frame_crc,
  output logic [CNT_W-1:0] pixel_count,
  output logic [CNT_W-1:0] frame_count,
  output logic             err_hperiod,
  output logic             err_hwidth,
  output logic             err_vperiod,
  output logic             err_blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL + 1);
  localparam int VC_W    = $clog2(V_TOTAL + 1);

  localparam logic [HC_W-1:0] H_MAX     = HC_W'(H_TOTAL);
  localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT_LO  = HC_W'(H_SYNC + H_BP);
  localparam logic [HC_W-1:0] H_ACT_HI  = HC_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HC_W-1:0] HSYNC_LEN = HC_W'(H_SYNC);
  localparam logic [VC_W-1:0] V_MAX     = VC_W'(V_TOTAL);
  localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT_LO  = VC_W'(V_SYNC + V_BP);
  localparam logic [VC_W-1:0] V_ACT_HI  = VC_W'(V_SYNC + V_BP + V_ACTIVE);

  // Bus value with both syncs inactive and all colours dark; used as the
  // reset image of the input register so the first real sync pulse after
  // reset is seen as a leading edge.
  localparam logic [7:0] VGA_IDLE = {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};

  // ---------------------------------------------------------------------
  // Input capture and sync edge detection
  // ---------------------------------------------------------------------
  logic [7:0] vga_q;
  logic       hs_now, vs_now;
  logic       hs_prev, vs_prev;
  logic       hs_lead, hs_trail, vs_lead;

  assign hs_now   = (vga_q[PIN_HSYNC] == SYNC_POL);
  assign vs_now   = (vga_q[PIN_VSYNC] == SYNC_POL);
  assign hs_lead  = hs_now & ~hs_prev;
  assign hs_trail = ~hs_now & hs_prev;
  assign vs_lead  = vs_now & ~vs_prev;

  // Single register stage on the pins, plus the previous sync levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_q   <= VGA_IDLE;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vga_q   <= vga_in;
      hs_prev <= hs_now;
      vs_prev <= vs_now;
    end
  end

  // ---------------------------------------------------------------------
  // Raster position. hcnt/vcnt/hrun describe the sample currently in
  // vga_q; the *_q registers hold the value for the previous sample, which
  // is what the period and width checks compare against.
  // ---------------------------------------------------------------------
  logic [HC_W-1:0] hcnt, hcnt_q;
  logic [HC_W-1:0] hrun, hrun_q;
  logic [VC_W-1:0] vcnt, vcnt_q;
  logic            active;

  // Next position: restart on sync edges, otherwise count and saturate
  always_comb begin
    hcnt = hcnt_q;
    if (hs_lead) begin
      hcnt = '0;
    end else if (hcnt_q != H_MAX) begin
      hcnt = hcnt_q + 1'b1;
    end

    vcnt = vcnt_q;
    if (vs_lead) begin
      vcnt = '0;
    end else if (hs_lead && (vcnt_q != V_MAX)) begin
      vcnt = vcnt_q + 1'b1;
    end

    hrun = hrun_q;
    if (hs_lead) begin
      hrun = HC_W'(1);
    end else if (hs_now && (hrun_q != H_MAX)) begin
      hrun = hrun_q + 1'b1;
    end
  end

  assign active = (hcnt >= H_ACT_LO) && (hcnt < H_ACT_HI) &&
                  (vcnt >= V_ACT_LO) && (vcnt < V_ACT_HI);

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hrun_q <= '0;
    end else begin
      hcnt_q <= hcnt;
      vcnt_q <= vcnt;
      hrun_q <= hrun;
    end
  end

  // ---------------------------------------------------------------------
  // Lock state machine and error detection
  // ---------------------------------------------------------------------
  mon_state_e state_q, state_d;
  logic       in_lock;
  logic       new_hperiod, new_hwidth, new_vperiod, new_blank;
  logic       any_new_err;
  logic       report;

  assign in_lock = (state_q == ST_LOCK);

  // Checks only run once aligned; the lock edge itself is never checked
  always_comb begin
    new_hperiod = in_lock && hs_lead && (hcnt_q != H_LAST);
    new_hwidth  = in_lock && hs_trail && (hrun_q != HSYNC_LEN);
    new_vperiod = in_lock && vs_lead && (vcnt_q != V_LAST);
    new_blank   = in_lock && !active && ((vga_q & COLOUR_MASK) != 8'h00);
    any_new_err = new_hperiod | new_hwidth | new_vperiod | new_blank;
    // Any error drops lock immediately, so reaching a vsync edge still in
    // LOCK means the whole frame since the previous edge was clean.
    report      = in_lock && vs_lead && !any_new_err;
  end

  // Next-state: lock on a vsync edge, fall back to SEEK on any new error
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEEK: if (vs_lead)     state_d = ST_LOCK;
      ST_LOCK: if (any_new_err) state_d = ST_SEEK;
      default:                  state_d = ST_SEEK;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEEK;
    end else begin
      state_q <= state_d;
    end
  end

  assign locked = in_lock;

  // Sticky flags: a fresh error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_hperiod <= 1'b0;
      err_hwidth  <= 1'b0;
      err_vperiod <= 1'b0;
      err_blank   <= 1'b0;
    end else begin
      err_hperiod <= new_hperiod | (err_hperiod & ~err_clr);
      err_hwidth  <= new_hwidth  | (err_hwidth  & ~err_clr);
      err_vperiod <= new_vperiod | (err_vperiod & ~err_clr);
      err_blank   <= new_blank   | (err_blank   & ~err_clr);
    end
  end

  // ---------------------------------------------------------------------
  // Frame signature
  // ---------------------------------------------------------------------
  logic [15:0]      crc_q, crc_next;
  logic [CNT_W-1:0] pix_acc_q;

  vga_crc16_step u_crc_step (
    .crc_in  (crc_q),
    .pixel   (pixel_bits(vga_q)),
    .crc_out (crc_next)
  );

  // Running CRC and pixel tally, restarted at every vsync edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= CRC_INIT;
      pix_acc_q <= '0;
    end else if (vs_lead) begin
      crc_q     <= CRC_INIT;
      pix_acc_q <= '0;
    end else if (active) begin
      crc_q     <= crc_next;
      pix_acc_q <= pix_acc_q + 1'b1;
    end
  end

  // Publish the finished frame on a clean vsync edge under lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_crc   <= '0;
      pixel_count <= '0;
      frame_count <= '0;
    end else begin
      frame_valid <= report;
      if (report) begin
        frame_crc   <= crc_q;
        pixel_count <= pix_acc_q;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor using a small 14x7 raster.
module tb_vga_frame_monitor;

  localparam int H_TOT = 14;
  localparam int V_TOT = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  vga_in;
  logic        err_clr;
  logic        locked, frame_valid;
  logic [15:0] frame_crc;
  logic [7:0]  pixel_count, frame_count;
  logic        err_hperiod, err_hwidth, err_vperiod, err_blank;

  vga_frame_monitor #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .CNT_W(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_in      (vga_in),
    .err_clr     (err_clr),
    .locked      (locked),
    .frame_valid (frame_valid),
    .frame_crc   (frame_crc),
    .pixel_count (pixel_count),
    .frame_count (frame_count),
    .err_hperiod (err_hperiod),
    .err_hwidth  (err_hwidth),
    .err_vperiod (err_vperiod),
    .err_blank   (err_blank)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_valid  = 0;
  logic [31:0] exp_q[$];          // {crc[15:0], pixel_count[7:0], frame_count[7:0]}
  bit          m_locked = 1'b0;
  bit          pend_ok  = 1'b0;
  logic [15:0] pend_crc;
  logic [7:0]  pend_pix;
  int          m_fcount = 0;
  int          last_fc  = -1;
  bit          wrap_seen = 1'b0;

  // per-frame stimulus options (-1 = off)
  int pmode;
  int inj_short, inj_blank, inj_wide, inj_clr_line, inj_clr_h, inj_rst_line;
  bit clr_chk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc6(input logic [15:0] c, input logic [5:0] p);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 5; i >= 0; i--) begin
      fb = r[15] ^ p[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic no_inj();
    inj_short = -1; inj_blank = -1; inj_wide = -1;
    inj_clr_line = -1; inj_clr_h = -1; inj_rst_line = -1;
    clr_chk = 1'b0;
  endtask

  // Drive one pixel clock and scoreboard any report seen after the edge
  task automatic tick(input logic [7:0] v);
    logic [31:0] e;
    vga_in = v;
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, frame_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("frame_crc", {16'd0, frame_crc}, {16'd0, e[31:16]});
        check("pixel_count", {24'd0, pixel_count}, {24'd0, e[15:8]});
        check("frame_count", {24'd0, frame_count}, {24'd0, e[7:0]});
      end
      if (last_fc == 255 && frame_count == 8'd0) wrap_seen = 1'b1;
      last_fc = int'(frame_count);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
    check({tag, "_crc"}, {16'd0, frame_crc}, 32'd0);
    check({tag, "_pixcnt"}, {24'd0, pixel_count}, 32'd0);
    check({tag, "_fcnt"}, {24'd0, frame_count}, 32'd0);
    check({tag, "_errs"}, {28'd0, err_hperiod, err_hwidth, err_vperiod, err_blank}, 32'd0);
  endtask

  // One full raster (line 0 carries vsync); applies the configured faults
  task automatic send_frame();
    logic [15:0] crc;
    int          npix;
    logic [7:0]  v;
    logic [5:0]  p;
    int          hlen;
    bit          frame_bad;
    if (!m_locked) begin
      m_locked = 1'b1;
    end else if (pend_ok) begin
      m_fcount++;
      exp_q.push_back({pend_crc, pend_pix, m_fcount[7:0]});
    end
    pend_ok   = 1'b0;
    frame_bad = (inj_short >= 0) || (inj_blank >= 0) || (inj_wide >= 0);
    crc  = 16'hFFFF;
    npix = 0;
    for (int ln = 0; ln < V_TOT; ln++) begin
      hlen = (ln == inj_short) ? H_TOT - 1 : H_TOT;
      for (int h = 0; h < hlen; h++) begin
        v    = 8'h00;
        v[7] = (h < ((ln == inj_wide) ? 3 : 2)) ? 1'b0 : 1'b1;
        v[3] = (ln < 1) ? 1'b0 : 1'b1;
        if (h >= 4 && h < 12 && ln >= 2 && ln < 6) begin
          p    = (pmode == 1) ? h[5:0] : 6'd0;
          v[0] = p[5]; v[4] = p[4]; v[1] = p[3];
          v[5] = p[2]; v[2] = p[1]; v[6] = p[0];
          crc  = crc6(crc, p);
          npix++;
        end
        if (ln == inj_blank && h == 12) v[0] = 1'b1;
        err_clr = (ln == inj_clr_line && h == inj_clr_h);
        if (ln == inj_rst_line && h == 6) begin
          rst_n = 1'b0;
          #2;
          check_all_zero("mid_reset");
          m_fcount  = 0;
          m_locked  = 1'b0;
          frame_bad = 1'b1;
        end
        tick(v);
        if (!rst_n) rst_n = 1'b1;
        if (clr_chk && ln == inj_clr_line && h == inj_clr_h) begin
          check("clr_flags", {28'd0, err_hperiod, err_hwidth, err_vperiod, err_blank}, 32'd0);
        end
      end
    end
    err_clr = 1'b0;
    if (frame_bad) begin
      m_locked = 1'b0;
    end else begin
      pend_ok  = m_locked;
      pend_crc = crc;
      pend_pix = npix[7:0];
    end
  endtask

  // ---------------- directed sequence ----------------
  int base_valid;

  initial begin
    rst_n   = 1'b0;
    vga_in  = 8'h88;
    err_clr = 1'b0;
    pmode   = 0;
    no_inj();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) tick(8'h88);

    // three clean black frames: lock, then two reports
    repeat (3) send_frame();
    check("clean_valid_count", n_valid, 32'd2);
    check("clean_frame_count", {24'd0, frame_count}, {24'd0, m_fcount[7:0]});
    check("clean_locked", {31'd0, locked}, 32'd1);
    check("clean_errs", {28'd0, err_hperiod, err_hwidth, err_vperiod, err_blank}, 32'd0);

    // one 13-clock line
    inj_short = 3;
    send_frame();
    no_inj();
    check("hperiod_flag", {31'd0, err_hperiod}, 32'd1);
    check("hperiod_locked", {31'd0, locked}, 32'd0);
    check("hperiod_valid_count", n_valid, 32'd3);

    // colour in the front porch (relock frame, so no report either)
    inj_blank = 6;
    send_frame();
    no_inj();
    check("blank_flag", {31'd0, err_blank}, 32'd1);
    check("blank_valid_count", n_valid, 32'd3);

    // clear with nothing new pending
    inj_clr_line = 1; inj_clr_h = 5; clr_chk = 1'b1;
    send_frame();
    no_inj();
    check("relock_locked", {31'd0, locked}, 32'd1);

    // wide hsync with err_clr on the very cycle it is detected
    inj_wide = 2; inj_clr_line = 2; inj_clr_h = 4;
    send_frame();
    no_inj();
    check("hwidth_flag", {31'd0, err_hwidth}, 32'd1);
    check("hwidth_others", {29'd0, err_hperiod, err_vperiod, err_blank}, 32'd0);
    check("hwidth_locked", {31'd0, locked}, 32'd0);
    check("hwidth_valid_count", n_valid, 32'd4);

    // reset in the middle of a frame
    inj_rst_line = 3;
    send_frame();
    no_inj();
    base_valid = n_valid;

    // counting pattern, 300 frames, frame_count wraps
    pmode = 1;
    send_frame();
    check("lock_frame_no_report", n_valid - base_valid, 32'd0);
    send_frame();
    check("first_report_after_rst", n_valid - base_valid, 32'd1);
    repeat (298) send_frame();
    check("pattern_frame_count", {24'd0, frame_count}, {24'd0, m_fcount[7:0]});
    check("pattern_wrap_seen", {31'd0, wrap_seen}, 32'd1);
    check("pattern_errs", {28'd0, err_hperiod, err_hwidth, err_vperiod, err_blank}, 32'd0);

    repeat (5) tick(8'h88);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clocks; H_TOTAL = sum of the four.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, in lines; V_TOTAL = sum of the four.
REQ-004 Parameter SYNC_POL, default 0, active level of both syncs (0 = active-low).
REQ-005 Parameter CNT_W, default 16, width of frame_count and pixel_count.
REQ-006 clk  input  1  pixel clock; the only clock in the block.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 vga_in  input  8  TinyVGA pinout: [7]=HSYNC, [6]=B0, [5]=G0, [4]=R0, [3]=VSYNC, [2]=B1, [1]=G1, [0]=R1.
REQ-009 err_clr  input  1  synchronous clear of the sticky error flags.
REQ-010 locked  output  1  high while in state LOCK.
REQ-011 frame_valid  output  1  single-cycle pulse at the end of a fully checked frame.
REQ-012 frame_crc  output  16  CRC of the last reported frame; held until the next report.
REQ-013 pixel_count  output  CNT_W  active pixels counted in the last reported frame.
REQ-014 frame_count  output  CNT_W  number of reported frames, wrapping modulo 2^CNT_W.
REQ-015 err_hperiod, err_hwidth, err_vperiod, err_blank  output  1 each  sticky error flags.

Function
REQ-016 vga_in SHALL be registered once; the leading edge of a sync is the first registered sample at SYNC_POL after a sample that is not at SYNC_POL.
REQ-017 hcnt SHALL be 0 on the cycle of an hsync leading edge, and SHALL otherwise increment, saturating at H_TOTAL.
REQ-018 vcnt SHALL be 0 on a vsync leading edge and SHALL otherwise increment on each hsync leading edge; when both edges occur in the same cycle, the vsync edge wins and vcnt = 0.
REQ-019 A sample is active iff H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE.
REQ-020 States: SEEK (reset state) and LOCK; SEEK->LOCK on a vsync leading edge; LOCK->SEEK on any new error.
REQ-021 In LOCK, an hsync leading edge with the previous hcnt != H_TOTAL-1 SHALL set err_hperiod.
REQ-022 In LOCK, the hsync active run length != H_SYNC SHALL set err_hwidth, checked on its trailing edge.
REQ-023 In LOCK, a vsync leading edge with the previous vcnt != V_TOTAL-1 SHALL set err_vperiod.
REQ-024 In LOCK, any nonzero colour bit on a non-active sample SHALL set err_blank.
REQ-025 CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR; 6 bits per active sample, MSB first, bit order {R1,R0,G1,G0,B1,B0}.
REQ-026 CRC and the pixel accumulator SHALL reinitialise on every vsync leading edge.
REQ-027 A vsync leading edge in LOCK with no error during the frame SHALL pulse frame_valid, latch frame_crc and pixel_count, and increment frame_count, all in that cycle.
REQ-028 The first vsync edge after SEEK SHALL only lock and SHALL NOT report a frame.
REQ-029 err_clr SHALL clear all flags; a new error in the same cycle SHALL win and the flag stays set.

Reset
REQ-030 On rst_n low: state=SEEK, counters=0, CRC=0xFFFF, all outputs=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the next report requires a lock edge plus one full frame.

Structure
REQ-032 Package vga_mon_pkg SHALL hold the TinyVGA pin-index constants, the CRC polynomial and init value, and the state enum.
REQ-033 Sub-module vga_crc16_step SHALL be a combinational block taking the CRC and a 6-bit pixel and producing the next CRC.
REQ-034 Timing parameters SHALL stay on the module so a single bench can run small test timings.

Verification (bench parameters H=8/2/2/2, V=4/1/1/1, H_TOTAL=14, V_TOTAL=7)
REQ-035 Three clean all-black frames -> frame_valid pulses twice, pixel_count=32, frame_count=2, CRC matches the model, no errors.
REQ-036 One line with an hsync period of 13 -> err_hperiod=1, locked=0, and no frame_valid pulse for that frame.
REQ-037 R1=1 set at hcnt=12 (front porch) -> err_blank=1; err_clr with no new error -> flag returns to 0 the next cycle.
REQ-038 err_clr in the same cycle as a new err_hwidth -> err_hwidth stays 1.
REQ-039 rst_n pulsed low mid-frame -> all outputs 0 immediately; the first report arrives at the second vsync edge after reset.
REQ-040 Counting pattern pixel = hcnt[5:0] for 300 frames with CNT_W=8 -> frame_count wraps 255->0 and the CRC is stable frame to frame.
